toggle_event_decoder: RTL and testbench

TOGGLE_EVENT_DECODER -- requirements
Module: toggle_event_decoder

---
 rtl/toggle_pkg.sv | 14 +
 rtl/sync_chain.sv | 29 ++
 rtl/toggle_event_decoder.sv | 114 +++++++++++
 tb/tb_toggle_event_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared state encoding and default sizing for the toggle event decoder.
// Latency: none (definitions only); backpressure: n/a.
package toggle_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int PEND_W_DEF      = 4;
   localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: STAGES cycles; backpressure: none.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Decodes toggle-encoded events into pulses, a pending queue count and a wrapping total.
// Latency: SYNC_STAGES+1 cycles to evt_pulse; backpressure: pend_cnt saturates and flags overflow.
module toggle_event_decoder
   import toggle_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int PEND_W      = PEND_W_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tog_in,
   input  logic              evt_ready,
   input  logic              clr_ovf,
   output logic              evt_pulse,
   output logic              evt_valid,
   output logic [PEND_W-1:0] pend_cnt,
   output logic [CNT_W-1:0]  total_cnt,
   output logic              overflow,
   output logic              level_out
);

   localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SYNC_STAGES);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   state_t              state_q, state_d;
   logic [FILL_W-1:0]   fill_cnt_q, fill_cnt_d;
   logic                prev_q, prev_d;
   logic                evt_pulse_q, evt_pulse_d;
   logic [PEND_W-1:0]   pend_cnt_q, pend_cnt_d;
   logic [CNT_W-1:0]    total_cnt_q, total_cnt_d;
   logic                overflow_q, overflow_d;
   logic                accept;
   logic                ovf_set;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tog_in),
      .q     (level_out)
   );

   // While filling, the chain still holds reset zeros; track the level without reporting edges.
   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      prev_d      = level_out;
      evt_pulse_d = 1'b0;
      case (state_q)
         FILL: begin
            if (fill_cnt_q == FILL_LAST) begin
               state_d = ARMED;
            end else begin
               fill_cnt_d = fill_cnt_q + FILL_W'(1);
            end
         end
         ARMED: begin
            evt_pulse_d = level_out ^ prev_q;
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   assign evt_valid = (pend_cnt_q != '0);
   assign accept    = evt_valid & evt_ready;
   assign ovf_set   = evt_pulse_q & ~accept & (pend_cnt_q == PEND_MAX);

   always_comb begin
      pend_cnt_d  = pend_cnt_q;
      total_cnt_d = total_cnt_q + CNT_W'(evt_pulse_q);
      overflow_d  = overflow_q;
      case ({evt_pulse_q, accept})
         2'b10:   pend_cnt_d = (pend_cnt_q == PEND_MAX) ? pend_cnt_q : pend_cnt_q + PEND_W'(1);
         2'b01:   pend_cnt_d = pend_cnt_q - PEND_W'(1);
         default: pend_cnt_d = pend_cnt_q;
      endcase
      if (ovf_set) begin
         overflow_d = 1'b1;
      end else if (clr_ovf) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         fill_cnt_q  <= '0;
         prev_q      <= 1'b0;
         evt_pulse_q <= 1'b0;
         pend_cnt_q  <= '0;
         total_cnt_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         prev_q      <= prev_d;
         evt_pulse_q <= evt_pulse_d;
         pend_cnt_q  <= pend_cnt_d;
         total_cnt_q <= total_cnt_d;
         overflow_q  <= overflow_d;
      end
   end

   assign evt_pulse = evt_pulse_q;
   assign pend_cnt  = pend_cnt_q;
   assign total_cnt = total_cnt_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench: per-cycle vector table plus hand sequences for overflow, wrap and mid-run reset.
module tb_toggle_event_decoder;

   logic       clk;
   logic       rst_n;
   logic       tog_in;
   logic       evt_ready;
   logic       clr_ovf;
   logic       evt_pulse;
   logic       evt_valid;
   logic [3:0] pend_cnt;
   logic [7:0] total_cnt;
   logic       overflow;
   logic       level_out;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic tog, rdy, clr;
      logic pulse;
      int   pend, total;
      logic ovf, valid, level;
   } vec_t;

   vec_t vecs[$];

   toggle_event_decoder #(
      .SYNC_STAGES (2),
      .PEND_W      (4),
      .CNT_W       (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tog_in    (tog_in),
      .evt_ready (evt_ready),
      .clr_ovf   (clr_ovf),
      .evt_pulse (evt_pulse),
      .evt_valid (evt_valid),
      .pend_cnt  (pend_cnt),
      .total_cnt (total_cnt),
      .overflow  (overflow),
      .level_out (level_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic row(input logic tg, input logic rd, input logic cl, input logic pu,
                      input int pe, input int to, input logic ov, input logic va, input logic lv);
      vec_t v;
      v.tog = tg; v.rdy = rd; v.clr = cl; v.pulse = pu;
      v.pend = pe; v.total = to; v.ovf = ov; v.valid = va; v.level = lv;
      vecs.push_back(v);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " pulse"}, 32'(evt_pulse), 0);
      chk({tag, " pend"}, 32'(pend_cnt), 0);
      chk({tag, " total"}, 32'(total_cnt), 0);
      chk({tag, " ovf"}, 32'(overflow), 0);
      chk({tag, " valid"}, 32'(evt_valid), 0);
      chk({tag, " level"}, 32'(level_out), 0);
   endtask

   // Enters reset away from a clock edge, checks cleared state, releases mid-cycle.
   task automatic do_reset(input logic tg);
      rst_n = 1'b0; tog_in = tg; evt_ready = 1'b0; clr_ovf = 1'b0;
      tick();
      tick();
      chk_zero("in_reset");
      rst_n = 1'b1;
   endtask

   initial begin
      int pulses;
      rst_n = 1'b0; tog_in = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;

      // tog rdy clr | pulse pend total ovf valid level  (one row per clock edge)
      row(1,0,0, 0,0,0,0,0,0);
      row(1,0,0, 0,0,0,0,0,1);
      row(1,0,0, 0,0,0,0,0,1);
      row(1,0,0, 0,0,0,0,0,1);
      row(0,0,0, 0,0,0,0,0,1);
      row(0,0,0, 0,0,0,0,0,0);
      row(0,0,0, 1,0,0,0,0,0);
      row(0,0,0, 0,1,1,0,1,0);
      row(1,0,0, 0,1,1,0,1,0);
      row(1,0,0, 0,1,1,0,1,1);
      row(1,0,0, 1,1,1,0,1,1);
      row(1,0,0, 0,2,2,0,1,1);
      row(0,0,0, 0,2,2,0,1,1);
      row(1,0,0, 0,2,2,0,1,0);
      row(0,0,0, 1,2,2,0,1,1);
      row(1,0,0, 1,3,3,0,1,0);
      row(0,0,0, 1,4,4,0,1,1);
      row(0,0,0, 1,5,5,0,1,0);
      row(0,0,0, 1,6,6,0,1,0);
      row(0,0,0, 0,7,7,0,1,0);
      row(1,1,0, 0,6,7,0,1,0);
      row(1,1,0, 0,5,7,0,1,1);
      row(1,1,0, 1,4,7,0,1,1);
      row(1,1,0, 0,4,8,0,1,1);
      row(1,1,0, 0,3,8,0,1,1);
      row(1,1,0, 0,2,8,0,1,1);
      row(1,1,0, 0,1,8,0,1,1);
      row(1,1,0, 0,0,8,0,0,1);
      row(1,1,0, 0,0,8,0,0,1);

      do_reset(1'b1);
      foreach (vecs[i]) begin
         tog_in = vecs[i].tog; evt_ready = vecs[i].rdy; clr_ovf = vecs[i].clr;
         tick();
         chk($sformatf("row%0d pulse", i), 32'(evt_pulse), 32'(vecs[i].pulse));
         chk($sformatf("row%0d pend", i), 32'(pend_cnt), vecs[i].pend);
         chk($sformatf("row%0d total", i), 32'(total_cnt), vecs[i].total);
         chk($sformatf("row%0d ovf", i), 32'(overflow), 32'(vecs[i].ovf));
         chk($sformatf("row%0d valid", i), 32'(evt_valid), 32'(vecs[i].valid));
         chk($sformatf("row%0d level", i), 32'(level_out), 32'(vecs[i].level));
      end

      // Saturation: 16 back-to-back events into a 15-deep pending counter.
      do_reset(1'b0);
      repeat (3) tick();
      for (int i = 0; i < 16; i++) begin
         tog_in = ~tog_in;
         tick();
      end
      repeat (4) tick();
      chk("sat pend", 32'(pend_cnt), 15);
      chk("sat ovf", 32'(overflow), 1);
      chk("sat total", 32'(total_cnt), 16);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      chk("clr ovf", 32'(overflow), 0);
      chk("clr pend", 32'(pend_cnt), 15);
      // Overflow set while clear is held: set must win on that edge.
      tog_in = ~tog_in;
      tick(); tick(); tick();
      chk("setwin pulse", 32'(evt_pulse), 1);
      clr_ovf = 1'b1;
      tick();
      chk("setwin ovf", 32'(overflow), 1);
      chk("setwin pend", 32'(pend_cnt), 15);
      chk("setwin total", 32'(total_cnt), 17);
      tick();
      clr_ovf = 1'b0;
      chk("setwin then clr", 32'(overflow), 0);

      // Total counter wrap after 256 events.
      do_reset(1'b0);
      repeat (3) tick();
      pulses = 0;
      for (int i = 0; i < 256; i++) begin
         tog_in = ~tog_in;
         tick();
         if (evt_pulse) pulses++;
      end
      repeat (4) begin
         tick();
         if (evt_pulse) pulses++;
      end
      chk("wrap pulses", 32'(pulses), 256);
      chk("wrap total", 32'(total_cnt), 0);
      chk("wrap pend", 32'(pend_cnt), 15);
      chk("wrap ovf", 32'(overflow), 1);

      // Reset asserted mid-burst, between clock edges.
      for (int i = 0; i < 7; i++) begin
         tog_in = ~tog_in;
         tick();
      end
      #3;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      for (int i = 0; i < 3; i++) begin
         tog_in = ~tog_in;
         tick();
      end
      tog_in = 1'b1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("rearm%0d pulse", i), 32'(evt_pulse), 0);
         chk($sformatf("rearm%0d pend", i), 32'(pend_cnt), 0);
         chk($sformatf("rearm%0d total", i), 32'(total_cnt), 0);
      end
      chk("rearm level", 32'(level_out), 1);
      tog_in = 1'b0;
      repeat (4) tick();
      chk("rearm evt pend", 32'(pend_cnt), 1);
      chk("rearm evt total", 32'(total_cnt), 1);
      chk("rearm evt valid", 32'(evt_valid), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
